// File: rtl/axi_txn_arbiter.sv
// axi_txn_arbiter: round-robin transaction-level master/slave grant for a shared-bus AXI crossbar
module axi_txn_arbiter #(
    parameter int NM = 3,
    parameter int NS = 6,
    parameter logic [2:0] NOGRANT = 3'b111
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic [NM-1:0]   arvalid_m,
    input  logic [NM-1:0]   awvalid_m,
    input  logic [4*NM-1:0] ar_target,
    input  logic [4*NM-1:0] aw_target,
    input  logic [NS-1:0]   arready_s,
    input  logic [NS-1:0]   awready_s,
    input  logic [NS-1:0]   rvalid_s,
    input  logic [NS-1:0]   rlast_s,
    input  logic [NM-1:0]   rready_m,
    input  logic [NS-1:0]   bvalid_s,
    input  logic [NM-1:0]   bready_m,
    output logic [2:0]      grant_m,
    output logic [2:0]      grant_s,
    output logic            grant_wr,
    output logic            busy
);
    localparam int PW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [PW:0] NMW = (PW+1)'(NM);
    localparam logic [3:0] NS4 = 4'(NS);

    typedef enum logic [2:0] {IDLE, R_ADDR, R_DATA, W_ADDR, W_RESP} state_t;

    state_t state;
    logic [PW-1:0] rr_ptr, m_q, win_m, idx;
    logic [SW-1:0] s_q, win_s;
    logic [PW:0] sum;
    logic [3:0] tw, tr;
    logic win, win_wr, done;

    // Scan masters from rr_ptr upward; first eligible wins, write preferred over read
    always_comb begin
        win = 1'b0;
        win_wr = 1'b0;
        win_m = '0;
        win_s = '0;
        idx = '0;
        sum = '0;
        tw = '0;
        tr = '0;
        for (int k = 0; k < NM; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            idx = (sum >= NMW) ? PW'(sum - NMW) : PW'(sum);
            tw = aw_target[{idx, 2'b00} +: 4];
            tr = ar_target[{idx, 2'b00} +: 4];
            if (!win && awvalid_m[idx] && tw < NS4) begin
                win = 1'b1;
                win_wr = 1'b1;
                win_m = idx;
                win_s = SW'(tw);
            end else if (!win && arvalid_m[idx] && tr < NS4) begin
                win = 1'b1;
                win_m = idx;
                win_s = SW'(tr);
            end
        end
    end

    // Completion: last R beat for reads, B handshake for writes
    always_comb begin
        done = (state == R_DATA) ? (rvalid_s[s_q] && rready_m[m_q] && rlast_s[s_q]) :
               (state == W_RESP) ? (bvalid_s[s_q] && bready_m[m_q]) : 1'b0;
    end

    // Transaction FSM with registered grant outputs; release forces one NOGRANT cycle
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
            grant_m <= NOGRANT;
            grant_s <= NOGRANT;
            grant_wr <= 1'b0;
            busy <= 1'b0;
            rr_ptr <= '0;
            m_q <= '0;
            s_q <= '0;
        end else if (done) begin
            state <= IDLE;
            grant_m <= NOGRANT;
            grant_s <= NOGRANT;
            grant_wr <= 1'b0;
            busy <= 1'b0;
            rr_ptr <= (m_q == PW'(NM-1)) ? '0 : m_q + PW'(1);
        end else begin
            case (state)
                IDLE: if (win) begin
                    state <= win_wr ? W_ADDR : R_ADDR;
                    m_q <= win_m;
                    s_q <= win_s;
                    grant_m <= 3'(win_m);
                    grant_s <= 3'(win_s);
                    grant_wr <= win_wr;
                    busy <= 1'b1;
                end
                R_ADDR: if (arvalid_m[m_q] && arready_s[s_q]) state <= R_DATA;
                W_ADDR: if (awvalid_m[m_q] && awready_s[s_q]) state <= W_RESP;
                R_DATA, W_RESP: state <= state;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_txn_arbiter.sv
// tb_axi_txn_arbiter: directed and randomized checks of the arbiter against a transaction-level model
module tb_axi_txn_arbiter;
    localparam int NM = 3;
    localparam int NS = 6;

    logic clk = 1'b0;
    logic rst;
    logic [NM-1:0] arvalid_m, awvalid_m, rready_m, bready_m;
    logic [4*NM-1:0] ar_target, aw_target;
    logic [NS-1:0] arready_s, awready_s, rvalid_s, rlast_s, bvalid_s;
    logic [2:0] grant_m, grant_s;
    logic grant_wr, busy;

    int checks = 0;
    int errors = 0;
    int log_q[$];
    bit prev_busy;
    int bad;

    // model: one transaction record, phase 0 = address, 1 = data/response
    bit mb, mwr, mph;
    int mm, ms, mptr;

    always #5 clk = ~clk;

    axi_txn_arbiter #(.NM(NM), .NS(NS)) dut (
        .ACLK(clk), .ARESET(rst),
        .arvalid_m(arvalid_m), .awvalid_m(awvalid_m),
        .ar_target(ar_target), .aw_target(aw_target),
        .arready_s(arready_s), .awready_s(awready_s),
        .rvalid_s(rvalid_s), .rlast_s(rlast_s), .rready_m(rready_m),
        .bvalid_s(bvalid_s), .bready_m(bready_m),
        .grant_m(grant_m), .grant_s(grant_s), .grant_wr(grant_wr), .busy(busy)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            mb = 0; mwr = 0; mph = 0; mm = 0; ms = 0; mptr = 0;
        end else if (!mb) begin
            for (int k = 0; k < NM; k++) begin
                int i, tw, tr;
                i = (mptr + k) % NM;
                tw = int'(aw_target[4*i +: 4]);
                tr = int'(ar_target[4*i +: 4]);
                if (awvalid_m[i] && tw < NS) begin
                    mb = 1; mwr = 1; mm = i; ms = tw; break;
                end else if (arvalid_m[i] && tr < NS) begin
                    mb = 1; mwr = 0; mm = i; ms = tr; break;
                end
            end
            mph = 0;
        end else if (!mph) begin
            mph = mwr ? (awvalid_m[mm] && awready_s[ms]) : (arvalid_m[mm] && arready_s[ms]);
        end else if (mwr ? (bvalid_s[ms] && bready_m[mm]) : (rvalid_s[ms] && rready_m[mm] && rlast_s[ms])) begin
            mb = 0;
            mptr = (mm + 1) % NM;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("grant_m", 8'(grant_m), mb ? 8'(mm) : 8'd7);
        check("grant_s", 8'(grant_s), mb ? 8'(ms) : 8'd7);
        check("grant_wr", 8'(grant_wr), 8'(mb && mwr));
        check("busy", 8'(busy), 8'(mb));
    endtask

    task automatic run_log(input int n);
        for (int c = 0; c < n; c++) begin
            step();
            if (busy && !prev_busy) log_q.push_back(int'(grant_m) * 2 + int'(grant_wr));
            prev_busy = busy;
        end
    endtask

    task automatic clear();
        arvalid_m = '0; awvalid_m = '0; rready_m = '0; bready_m = '0;
        ar_target = '0; aw_target = '0;
        arready_s = '0; awready_s = '0; rvalid_s = '0; rlast_s = '0; bvalid_s = '0;
    endtask

    task automatic do_reset();
        clear();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        clear();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_rr_ptr", 8'(dut.rr_ptr), 8'd0);

        // 1: M0 4-beat read from slave 0, ARREADY late
        arvalid_m = 3'b001;
        step();
        check("t1_grant_m", 8'(grant_m), 8'd0);
        check("t1_grant_s", 8'(grant_s), 8'd0);
        step();
        arready_s = 6'b000001;
        step();
        arvalid_m = '0; arready_s = '0;
        rvalid_s = 6'b000001; rready_m = 3'b001;
        for (int b = 1; b <= 4; b++) begin
            rlast_s = (b == 4) ? 6'b000001 : 6'b000000;
            step();
            check("t1_beat", 8'(grant_m), (b < 4) ? 8'd0 : 8'd7);
        end
        clear();
        step();

        // 2a: M1 and M2 write together with rr_ptr=0
        do_reset();
        awvalid_m = 3'b110; aw_target = 12'h310;
        awready_s = '1; bvalid_s = '1; bready_m = '1;
        log_q.delete(); prev_busy = 0;
        run_log(8);
        check("t2a_first", 8'(log_q.size() > 0 ? log_q[0] : -1), 8'd3);
        check("t2a_second", 8'(log_q.size() > 1 ? log_q[1] : -1), 8'd5);

        // 2b: M1 alone first so rr_ptr=2, then both -> M2 first
        do_reset();
        awvalid_m = 3'b010; aw_target = 12'h310;
        awready_s = '1; bvalid_s = '1; bready_m = '1;
        step(); step(); step();
        check("t2b_rr_ptr", 8'(dut.rr_ptr), 8'd2);
        awvalid_m = 3'b110;
        log_q.delete(); prev_busy = 0;
        run_log(8);
        check("t2b_first", 8'(log_q.size() > 0 ? log_q[0] : -1), 8'd5);
        check("t2b_second", 8'(log_q.size() > 1 ? log_q[1] : -1), 8'd3);

        // 3: M1 read and write to slave 2 together -> write first
        do_reset();
        arvalid_m = 3'b010; awvalid_m = 3'b010;
        ar_target = 12'h020; aw_target = 12'h020;
        arready_s = 6'b000100; awready_s = 6'b000100;
        step();
        check("t3_wr_first", 8'(grant_wr), 8'd1);
        check("t3_m", 8'(grant_m), 8'd1);
        step();
        awvalid_m = '0;
        bvalid_s = 6'b000100; bready_m = 3'b010;
        step();
        bvalid_s = '0;
        step();
        check("t3_rd_second", 8'(grant_wr), 8'd0);
        check("t3_rd_m", 8'(grant_m), 8'd1);
        step();
        arvalid_m = '0;
        rvalid_s = 6'b000100; rlast_s = 6'b000100; rready_m = 3'b010;
        step();
        check("t3_done", 8'(busy), 8'd0);

        // 4: M2 writes to unmapped slave 9, M0 reads slave 5
        do_reset();
        awvalid_m = 3'b100; aw_target = 12'h900;
        arvalid_m = 3'b001; ar_target = 12'h005;
        arready_s = '1; rvalid_s = '1; rlast_s = '1; rready_m = '1;
        bad = 0;
        step();
        check("t4_m0", 8'(grant_m), 8'd0);
        for (int c = 0; c < 12; c++) begin
            step();
            if (grant_m == 3'd2) bad++;
            if (busy && grant_s != 3'd5) bad++;
        end
        check("t4_m2_never", 8'(bad), 8'd0);

        // 5: BVALID with BREADY low for 5 cycles
        do_reset();
        awvalid_m = 3'b001; aw_target = 12'h003; awready_s = 6'b001000;
        step(); step();
        awvalid_m = '0;
        bvalid_s = 6'b001000;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t5_hold_m", 8'(grant_m), 8'd0);
            check("t5_hold_s", 8'(grant_s), 8'd3);
        end
        bready_m = 3'b001;
        step();
        check("t5_release", 8'(grant_m), 8'd7);
        clear();

        // 6: reset mid R_DATA with rr_ptr=1
        arvalid_m = 3'b001; ar_target = 12'h001; arready_s = 6'b000010;
        step(); step();
        arvalid_m = '0;
        rvalid_s = 6'b000010; rready_m = 3'b001;
        step(); step();
        check("t6_busy_before", 8'(busy), 8'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_grant_m", 8'(grant_m), 8'd7);
        check("t6_grant_s", 8'(grant_s), 8'd7);
        check("t6_busy", 8'(busy), 8'd0);
        check("t6_rr_ptr", 8'(dut.rr_ptr), 8'd0);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            arvalid_m = NM'($urandom); awvalid_m = NM'($urandom);
            rready_m = NM'($urandom); bready_m = NM'($urandom);
            for (int i = 0; i < NM; i++) begin
                ar_target[4*i +: 4] = 4'($urandom_range(0, 9));
                aw_target[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            arready_s = NS'($urandom); awready_s = NS'($urandom);
            rvalid_s = NS'($urandom); rlast_s = NS'($urandom); bvalid_s = NS'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
